// File: rtl/fmul_pkg.sv
// Shared definitions for the exponent-sum pipeline: parameter helpers and
// the result-class encoding produced by the classifier.
package fmul_pkg;

  typedef enum logic [2:0] {
    NORMAL    = 3'd0,
    INF_EDGE  = 3'd1,
    OVERFLOW  = 3'd2,
    DENORM    = 3'd3,
    UNDERFLOW = 3'd4
  } res_class_e;

  function automatic int bias_default(input int exp_w);
    return 2 ** (exp_w - 1) - 1;
  endfunction

  // Shift output must encode 0 .. MANT_W+2.
  function automatic int shift_width(input int mant_w);
    return $clog2(mant_w + 3);
  endfunction

endpackage

// File: rtl/exp_sum_pipe_if.sv
// Operand/result handshake bundle for exp_sum_pipe.
interface exp_sum_pipe_if
  import fmul_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) ();
  localparam int SHIFT_W = shift_width(MANT_W);

  logic               in_valid;
  logic               in_ready;
  logic               mode;
  logic [EXP_W-1:0]   exp_a;
  logic [EXP_W-1:0]   exp_b;
  logic               out_valid;
  logic               out_ready;
  logic [EXP_W-1:0]   exp_res;
  logic [SHIFT_W-1:0] denorm_shift;
  logic               prev_inf;
  logic               prev_overflow;
  logic               prev_denorm;
  logic               underflow;

  modport master (
    output in_valid, mode, exp_a, exp_b, out_ready,
    input  in_ready, out_valid, exp_res, denorm_shift,
           prev_inf, prev_overflow, prev_denorm, underflow
  );

  modport slave (
    input  in_valid, mode, exp_a, exp_b, out_ready,
    output in_ready, out_valid, exp_res, denorm_shift,
           prev_inf, prev_overflow, prev_denorm, underflow
  );
endinterface

// File: rtl/exp_sum_class.sv
// Combinational classification of the signed biased exponent sum into
// saturated exponent, subnormal shift and result class.
module exp_sum_class
  import fmul_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  localparam int SW      = EXP_W + 2,
  localparam int SHIFT_W = shift_width(MANT_W)
) (
  input  logic signed [SW-1:0] sum,
  output res_class_e           cls,
  output logic [EXP_W-1:0]     exp_res,
  output logic [SHIFT_W-1:0]   shift
);
  localparam logic signed [SW-1:0] OVF_TH    = SW'(2 ** EXP_W);
  localparam logic signed [SW-1:0] INF_VAL   = SW'(2 ** EXP_W - 1);
  localparam logic signed [SW-1:0] SHIFT_CAP = SW'(MANT_W + 2);

  logic signed [SW-1:0] neg_sum;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    neg_sum = -sum;
    cls     = NORMAL;
    exp_res = sum[EXP_W-1:0];
    shift   = '0;
    if (sum >= OVF_TH) begin
      cls     = OVERFLOW;
      exp_res = '1;
    end else if (sum == INF_VAL) begin
      cls     = INF_EDGE;
      exp_res = '1;
    end else if (sum <= 0) begin
      exp_res = '0;
      // Anything shifted past MANT_W+1 places loses every mantissa bit.
      if (neg_sum >= SHIFT_CAP) begin
        cls   = UNDERFLOW;
        shift = SHIFT_W'(MANT_W + 2);
      end else begin
        cls   = DENORM;
        shift = neg_sum[SHIFT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/exp_sum_pipe.sv
// Two-stage exponent adder for FP multiply/divide: stage 1 holds the biased
// sum, stage 2 holds its classification; valid/ready on both sides.
module exp_sum_pipe
  import fmul_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int BIAS   = bias_default(EXP_W)
) (
  input logic          clk,
  input logic          rst,
  exp_sum_pipe_if.slave bus
);
  localparam int SW      = EXP_W + 2;
  localparam int SHIFT_W = shift_width(MANT_W);

  logic                 s1_valid_q, s1_valid_d;
  logic signed [SW-1:0] s1_sum_q, s1_sum_d;
  logic                 s2_valid_q, s2_valid_d;
  res_class_e           s2_cls_q, s2_cls_d;
  logic [EXP_W-1:0]     s2_exp_q, s2_exp_d;
  logic [SHIFT_W-1:0]   s2_shift_q, s2_shift_d;

  logic [EXP_W-1:0]     eff_a, eff_b;
  logic signed [SW-1:0] sum_new;
  logic                 s2_load, s1_adv, in_fire;
  res_class_e           cls_c;
  logic [EXP_W-1:0]     exp_c;
  logic [SHIFT_W-1:0]   shift_c;

  exp_sum_class #(
    .EXP_W (EXP_W),
    .MANT_W(MANT_W)
  ) u_class (
    .sum    (s1_sum_q),
    .cls    (cls_c),
    .exp_res(exp_c),
    .shift  (shift_c)
  );

  always_comb begin
    // A zero field denotes a subnormal operand whose effective exponent is 1.
    eff_a   = (bus.exp_a == '0) ? EXP_W'(1) : bus.exp_a;
    eff_b   = (bus.exp_b == '0) ? EXP_W'(1) : bus.exp_b;
    sum_new = bus.mode
            ? $signed({2'b00, eff_a}) - $signed({2'b00, eff_b}) + $signed(SW'(BIAS))
            : $signed({2'b00, eff_a}) + $signed({2'b00, eff_b}) - $signed(SW'(BIAS));

    s2_load     = ~s2_valid_q | bus.out_ready;
    s1_adv      = s1_valid_q & s2_load;
    bus.in_ready = ~rst & (~s1_valid_q | s1_adv);
    in_fire     = bus.in_valid & bus.in_ready;

    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_sum_d   = sum_new;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    s2_cls_d   = s2_cls_q;
    s2_exp_d   = s2_exp_q;
    s2_shift_d = s2_shift_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_cls_d   = cls_c;
      s2_exp_d   = exp_c;
      s2_shift_d = shift_c;
    end else if (s2_valid_q && bus.out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // NOTE: data registers are cleared on reset along with the valid bits, so
  // result outputs read 0 after reset rather than stale operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_cls_q   <= NORMAL;
      s2_exp_q   <= '0;
      s2_shift_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      s2_valid_q <= s2_valid_d;
      s2_cls_q   <= s2_cls_d;
      s2_exp_q   <= s2_exp_d;
      s2_shift_q <= s2_shift_d;
    end
  end

  assign bus.out_valid     = s2_valid_q;
  assign bus.exp_res       = s2_exp_q;
  assign bus.denorm_shift  = s2_shift_q;
  assign bus.prev_overflow = (s2_cls_q == OVERFLOW);
  assign bus.prev_inf      = (s2_cls_q == INF_EDGE);
  assign bus.prev_denorm   = (s2_cls_q == DENORM) || (s2_cls_q == UNDERFLOW);
  assign bus.underflow     = (s2_cls_q == UNDERFLOW);

endmodule

// File: tb/tb_exp_sum_pipe.sv
// Scoreboard bench for exp_sum_pipe: directed vectors push hand-computed
// results; a negedge monitor pops and compares on every output transfer.
module tb_exp_sum_pipe;
  typedef struct packed {
    logic [7:0] e;
    logic [4:0] sh;
    logic       ovf;
    logic       inf;
    logic       den;
    logic       unf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  res_t cur, snap;
  bit   have_snap = 0;

  exp_sum_pipe_if #(.EXP_W(8), .MANT_W(23)) bus ();

  exp_sum_pipe #(.EXP_W(8), .MANT_W(23), .BIAS(127)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t mk(input int e, input int sh, input bit ovf, input bit inf,
                              input bit den, input bit unf);
    res_t r;
    r.e = 8'(e); r.sh = 5'(sh);
    r.ovf = ovf; r.inf = inf; r.den = den; r.unf = unf;
    return r;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic m, input logic [7:0] a, input logic [7:0] b, input res_t r);
    bit ok = 0;
    bus.mode = m; bus.exp_a = a; bus.exp_b = b; bus.in_valid = 1'b1;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(r);
        ok = 1;
      end
    end
    check("accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      cur = {bus.exp_res, bus.denorm_shift, bus.prev_overflow, bus.prev_inf,
             bus.prev_denorm, bus.underflow};
      if (have_snap) check("hold", 32'(cur), 32'(snap));
      if (bus.out_ready) begin
        have_snap = 0;
        if (exp_q.size() == 0) check("unexpected_out", 32'(cur), 32'h0_dead);
        else check("result", 32'(cur), 32'(exp_q.pop_front()));
      end else begin
        snap = cur;
        have_snap = 1;
      end
    end else begin
      have_snap = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.mode = 1'b0; bus.exp_a = '0; bus.exp_b = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_outputs", 32'({bus.exp_res, bus.denorm_shift, bus.prev_overflow,
                              bus.prev_inf, bus.prev_denorm, bus.underflow}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed vectors, back to back with out_ready held high.
    send(0, 8'd127, 8'd127, mk(127, 0, 0, 0, 0, 0));
    send(0, 8'd200, 8'd200, mk(255, 0, 1, 0, 0, 0));
    send(0, 8'd191, 8'd191, mk(255, 0, 0, 1, 0, 0));
    send(0, 8'd60,  8'd60,  mk(0,   7, 0, 0, 1, 0));
    send(0, 8'd64,  8'd63,  mk(0,   0, 0, 0, 1, 0));
    send(0, 8'd20,  8'd20,  mk(0,  25, 0, 0, 1, 1));
    send(0, 8'd0,   8'd127, mk(1,   0, 0, 0, 0, 0));
    send(1, 8'd127, 8'd254, mk(0,   0, 0, 0, 1, 0));
    send(1, 8'd254, 8'd1,   mk(255, 0, 1, 0, 0, 0));
    send(0, 8'd100, 8'd50,  mk(23,  0, 0, 0, 0, 0));
    send(0, 8'd63,  8'd63,  mk(0,   1, 0, 0, 1, 0));
    send(0, 8'd40,  8'd62,  mk(0,  25, 0, 0, 1, 1));
    send(0, 8'd41,  8'd62,  mk(0,  24, 0, 0, 1, 0));
    send(0, 8'd191, 8'd190, mk(254, 0, 0, 0, 0, 0));
    send(1, 8'd0,   8'd0,   mk(127, 0, 0, 0, 0, 0));
    drain();

    // Backpressure: two accepted, then in_ready drops and outputs hold.
    bus.out_ready = 1'b0;
    fork
      begin
        send(0, 8'd130, 8'd130, mk(133, 0, 0, 0, 0, 0));
        send(0, 8'd128, 8'd129, mk(130, 0, 0, 0, 0, 0));
        send(1, 8'd200, 8'd100, mk(227, 0, 0, 0, 0, 0));
        send(0, 8'd10,  8'd10,  mk(0,  25, 0, 0, 1, 1));
      end
      begin
        repeat (3) @(negedge clk);
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two transactions in flight: both must be discarded.
    bus.out_ready = 1'b0;
    send(0, 8'd150, 8'd150, mk(173, 0, 0, 0, 0, 0));
    send(0, 8'd140, 8'd140, mk(153, 0, 0, 0, 0, 0));
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rst_hold_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_exp_res", 32'(bus.exp_res), 32'd0);
    @(posedge clk); #1 rst = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    check("flush_no_out", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    send(0, 8'd128, 8'd128, mk(129, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("latency_cycle1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("latency_cycle2", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
    drain();
    repeat (3) @(negedge clk);
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exp_sum_pipe.md
EXP_SUM_PIPE -- requirements
Module: exp_sum_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MANT_W, default 23, stored mantissa width; sets the denorm shift cap.
REQ-003 SHALL have parameter BIAS, default 2**(EXP_W-1)-1, exponent bias.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk, the clock; rst, the reset.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  operand pair presented.
REQ-008 in_ready  output  1  block accepts operand pair this cycle.
REQ-009 mode  input  1  0 = multiply, 1 = divide.
REQ-010 exp_a, exp_b  input  EXP_W  biased operand exponents.
REQ-011 out_valid  output  1  result presented.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 exp_res  output  EXP_W  saturated biased result exponent.
REQ-014 denorm_shift  output  SHIFT_W  right shift for a subnormal result; SHIFT_W = clog2(MANT_W+3).
REQ-015 prev_inf, prev_overflow, prev_denorm, underflow  output  1 each  result class flags.

Function
REQ-016 Effective exponent SHALL be 1 when the field is 0, otherwise the field value.
REQ-017 Signed sum S (EXP_W+2 bits) SHALL be ea+eb-BIAS when mode=0, and ea-eb+BIAS when mode=1.
REQ-018 Stage 1 SHALL register S; stage 2 SHALL register classification; latency SHALL be exactly 2 cycles with no stall.
REQ-019 A transfer SHALL occur on in_valid&in_ready (input) or out_valid&out_ready (output); throughput SHALL be 1 per cycle.
REQ-020 Each stage SHALL load when empty or when its content moves on the same cycle; in_ready = ~s1_valid | s1 advancing, computed combinationally.
REQ-021 While out_valid&~out_ready, all outputs SHALL hold stable; no transaction is dropped or duplicated, and order is preserved.
REQ-022 prev_overflow SHALL be 1 iff S >= 2**EXP_W; exp_res = all ones.
REQ-023 prev_inf SHALL be 1 iff S == 2**EXP_W-1; exp_res = all ones.
REQ-024 prev_denorm SHALL be 1 iff S <= 0; exp_res = 0; denorm_shift = min(-S, MANT_W+2).
REQ-025 underflow SHALL be 1 iff -S > MANT_W+1; it always coincides with prev_denorm.
REQ-026 For 0 < S < 2**EXP_W-1: exp_res = S[EXP_W-1:0], all flags 0, denorm_shift 0.
REQ-027 At most one of prev_overflow, prev_inf, prev_denorm SHALL be 1 per result.
REQ-028 Special operands (inf/NaN fields) SHALL NOT be detected here; the upstream special-case path owns them.

Reset
REQ-029 On rst, s1_valid, s2_valid and all data registers SHALL clear to 0; out_valid=0 and all result outputs=0 on the next cycle.
REQ-030 in_ready SHALL be 0 while rst=1, and 1 in the first cycle after rst deasserts.
REQ-031 A transaction in flight when rst asserts SHALL be discarded and never emitted.

Structure
REQ-032 Package fmul_pkg SHALL hold the BIAS default function, the SHIFT_W derivation function and the result-class encoding (NORMAL, INF_EDGE, OVERFLOW, DENORM, UNDERFLOW).
REQ-033 Combinational classification of S SHALL be a sub-module exp_sum_class, instantiated before the stage-2 registers.

Verification (EXP_W=8, MANT_W=23, BIAS=127)
REQ-034 mode=0, a=127, b=127 -> two cycles later exp_res=127, all flags 0, shift 0.
REQ-035 mode=0: 200+200 -> prev_overflow=1, exp_res=255. 191+191 -> prev_inf=1, exp_res=255.
REQ-036 mode=0: 60+60 -> prev_denorm=1, shift=7, exp_res=0. 64+63 -> prev_denorm=1, shift=0. 20+20 -> shift=25, underflow=1. 0+127 -> ea=1, S=1, normal.
REQ-037 mode=1: 127/254 -> S=0, prev_denorm=1. 254/1 -> S=380, prev_overflow=1.
REQ-038 Back-to-back 4 inputs with out_ready=0 for 3 cycles -> in_ready falls after 2 accepted, outputs stable, all 4 emerge in order once out_ready=1.
REQ-039 rst pulsed with 2 in flight -> no out_valid afterwards; the next input emerges correctly after 2 cycles.
